q88_multiplier: RTL and testbench

Signed fixed-point multiplier for Q8.8 operands: 8 integer bits including sign, 8 fraction bits, so 0x0100 = 1.0. It serves the activation and neuron datapath, e.g. slope×input in the piecewise-linear sigmoid. It is an iterative shift-add unit with a start/done handshake. The result is rescaled to Q8.8, and saturation is configurable.

---
 rtl/q88_multiplier.sv | 104 ++++++++++
 tb/tb_q88_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/q88_multiplier.sv
// Signed Q8.8 iterative shift-add multiplier with start/busy/done handshake.
// WIDTH+1 cycles from start to done; product rescaled by FRAC, saturating or wrapping on overflow.
module q88_multiplier #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ab,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]          w_mag_a;
  logic [WIDTH-1:0]          w_mag_b;
  logic signed [2*WIDTH-1:0] w_signed;
  logic signed [2*WIDTH-1:0] w_shift;
  logic [WIDTH:0]            w_top;
  logic                      w_ovf;
  logic [WIDTH-1:0]          w_sat;
  logic [WIDTH-1:0]          w_res;

  // Magnitude of the most negative value is read as unsigned, so -128.0 works.
  assign w_mag_a = a[WIDTH-1] ? (~a + ONE_W) : a;
  assign w_mag_b = b[WIDTH-1] ? (~b + ONE_W) : b;

  assign w_signed = r_neg ? $signed(~r_acc + ONE_2W) : $signed(r_acc);
  assign w_shift  = w_signed >>> FRAC;

  // In range only when every bit above the result sign bit matches it.
  assign w_top = w_shift[2*WIDTH-1:WIDTH-1];
  assign w_ovf = ~(&w_top) & (|w_top);
  assign w_sat = w_shift[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_res = ((SATURATE != 0) && w_ovf) ? w_sat : w_shift[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      ab       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          ab       <= w_res;
          overflow <= w_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q88_multiplier.sv
// Directed bench for q88_multiplier: saturating and wrapping instances share stimulus.
module tb_q88_multiplier;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  ab, ab_w;
  logic          busy, done, overflow;
  logic          busy_w, done_w, overflow_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  q88_multiplier #(.WIDTH(W), .FRAC(8), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ab(ab), .busy(busy), .done(done), .overflow(overflow)
  );

  q88_multiplier #(.WIDTH(W), .FRAC(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ab(ab_w), .busy(busy_w), .done(done_w), .overflow(overflow_w)
  );

  // Issue one operation and return cycles from the accepting edge to done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    #1;
    n_checks++; if (ab !== 16'h0000) begin n_fail++; $display("FAIL reset_ab got %h want 0000", ab); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (ab !== 16'h0000) begin n_fail++; $display("FAIL midop_reset_ab got %h want 0000", ab); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midop_reset_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_identity();
    int lat;
    run_op(16'h0100, 16'h0100, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL ident_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (ab !== 16'h0100) begin n_fail++; $display("FAIL ident_ab got %h want 0100", ab); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ident_ovf got %b want 0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ident_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ident_done_single got %b want 0", done); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (ab !== 16'h0100) begin n_fail++; $display("FAIL ident_ab_hold got %h want 0100", ab); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [8] = '{16'h0080, 16'hFF00, 16'hFFFF, 16'h0000, 16'h8000, 16'h4000, 16'hC000, 16'h8000};
    logic [W-1:0] vb [8] = '{16'h0200, 16'h0180, 16'h0080, 16'hFF00, 16'h0100, 16'h0400, 16'h0400, 16'hFF00};
    logic [W-1:0] ve [8] = '{16'h0100, 16'hFE80, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic         vo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], lat);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, LAT); end
      n_checks++;
      if (ab !== ve[i]) begin n_fail++; $display("FAIL vec%0d_ab %h*%h got %h want %h", i, va[i], vb[i], ab, ve[i]); end
      n_checks++;
      if (overflow !== vo[i]) begin n_fail++; $display("FAIL vec%0d_ovf got %b want %b", i, overflow, vo[i]); end
    end
  endtask

  task automatic test_wrap();
    int lat;
    run_op(16'h4000, 16'h0400, lat);
    n_checks++; if (ab_w !== 16'h0000) begin n_fail++; $display("FAIL wrap_pos_ab got %h want 0000", ab_w); end
    n_checks++; if (overflow_w !== 1'b1) begin n_fail++; $display("FAIL wrap_pos_ovf got %b want 1", overflow_w); end
    run_op(16'h8000, 16'hFF00, lat);
    n_checks++; if (ab_w !== 16'h8000) begin n_fail++; $display("FAIL wrap_min_ab got %h want 8000", ab_w); end
    n_checks++; if (overflow_w !== 1'b1) begin n_fail++; $display("FAIL wrap_min_ovf got %b want 1", overflow_w); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin
        a = 16'h4000; b = 16'h0400; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (ab !== 16'h0100) begin n_fail++; $display("FAIL b2b_ignored_start_ab got %h want 0100", ab); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored_start_ovf got %b want 0", overflow); end
    // Launch the next operation while done is still high.
    a = 16'h0300; b = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (ab !== 16'h0600) begin n_fail++; $display("FAIL b2b_second_ab got %h want 0600", ab); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_vectors();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
